raster_timing_gen: RTL and testbench

// Parametrised raster position generator, successor to the fixed-chip raster counter.

---
 rtl/raster_timing_gen.sv | 146 ++++++++++++++
 tb/tb_raster_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/raster_timing_gen.sv
// Raster position generator: pixel/line counters, remapped xpos, sprite x, field tracking,
// line/frame strobes and a raster-compare IRQ, all advancing on the dot-rate enable.
module raster_timing_gen #(
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 9,
  parameter int unsigned XpW     = 10,
  parameter int unsigned NumJump = 4,
  parameter int unsigned BlinkW  = 6
) (
  input  logic                   clk_dot4x_i,
  input  logic                   rst_i,
  input  logic                   dot_tick_i,
  input  logic [XW-1:0]          x_max_i,
  input  logic [YW-1:0]          y_max_i,
  input  logic                   interlace_en_i,
  input  logic [XpW-1:0]         xpos_start_i,
  input  logic [XW-1:0]          spr_offset_i,
  input  logic [NumJump-1:0]     jump_en_i,
  input  logic [NumJump*XW-1:0]  jump_at_i,
  input  logic [NumJump*XpW-1:0] jump_to_i,
  input  logic [YW-1:0]          raster_cmp_i,
  input  logic                   cmp_en_i,
  output logic [XW-1:0]          raster_x_o,
  output logic [YW-1:0]          raster_line_o,
  output logic [XpW-1:0]         xpos_o,
  output logic [XW-1:0]          sprite_raster_x_o,
  output logic                   field_o,
  output logic [BlinkW-1:0]      blink_ctr_o,
  output logic                   sol_o,
  output logic                   sof_o,
  output logic                   irq_raster_o
);

  logic [XW-1:0]     raster_x_q, raster_x_d;
  logic [YW-1:0]     raster_line_q, raster_line_d;
  logic [XpW-1:0]    xpos_q, xpos_d;
  logic [XW-1:0]     spr_x_q, spr_x_d;
  logic              field_q, field_d;
  logic [BlinkW-1:0] blink_q, blink_d;
  logic              sol_q, sol_d;
  logic              sof_q, sof_d;
  logic              irq_q, irq_d;
  logic              match_q, match_d;
  logic [XW-1:0]     x_max_l_q, x_max_l_d;
  logic [YW-1:0]     y_max_l_q, y_max_l_d;

  logic              line_wrap;
  logic              frame_wrap;
  logic [YW-1:0]     ylim;
  logic              jump_hit;
  logic [XpW-1:0]    jump_xpos;
  logic              cmp_match;

  always_comb begin
    line_wrap  = raster_x_q >= x_max_l_q;
    ylim       = y_max_l_q + {{(YW-1){1'b0}}, interlace_en_i & field_q};
    frame_wrap = line_wrap && !(raster_line_q < ylim);
    cmp_match  = cmp_en_i && (raster_line_q == raster_cmp_i);

    // Scan high to low so the lowest matching entry wins.
    jump_hit  = 1'b0;
    jump_xpos = '0;
    for (int i = int'(NumJump) - 1; i >= 0; i--) begin
      if (jump_en_i[i] && (raster_x_q == jump_at_i[i*XW +: XW])) begin
        jump_hit  = 1'b1;
        jump_xpos = jump_to_i[i*XpW +: XpW];
      end
    end

    raster_x_d    = raster_x_q;
    raster_line_d = raster_line_q;
    xpos_d        = xpos_q;
    spr_x_d       = spr_x_q;
    field_d       = field_q;
    blink_d       = blink_q;
    x_max_l_d     = x_max_l_q;
    y_max_l_d     = y_max_l_q;
    sol_d         = 1'b0;
    sof_d         = 1'b0;
    irq_d         = cmp_match & ~match_q;
    match_d       = cmp_match;

    if (dot_tick_i) begin
      spr_x_d = (spr_x_q < x_max_l_q) ? spr_x_q + XW'(1) : '0;
      if (line_wrap) begin
        raster_x_d = '0;
        xpos_d     = xpos_start_i;
        sol_d      = 1'b1;
        if (frame_wrap) begin
          raster_line_d = '0;
          blink_d       = blink_q + BlinkW'(1);
          field_d       = interlace_en_i ? ~field_q : 1'b0;
          x_max_l_d     = x_max_i;
          y_max_l_d     = y_max_i;
          sof_d         = 1'b1;
        end else begin
          raster_line_d = raster_line_q + YW'(1);
        end
      end else begin
        raster_x_d = raster_x_q + XW'(1);
        xpos_d     = jump_hit ? jump_xpos : xpos_q + XpW'(1);
      end
    end
  end

  always_ff @(posedge clk_dot4x_i) begin
    if (rst_i) begin
      raster_x_q    <= '0;
      raster_line_q <= '0;
      xpos_q        <= xpos_start_i;
      spr_x_q       <= spr_offset_i;
      field_q       <= 1'b0;
      blink_q       <= '0;
      sol_q         <= 1'b0;
      sof_q         <= 1'b0;
      irq_q         <= 1'b0;
      match_q       <= 1'b0;
      x_max_l_q     <= x_max_i;
      y_max_l_q     <= y_max_i;
    end else begin
      raster_x_q    <= raster_x_d;
      raster_line_q <= raster_line_d;
      xpos_q        <= xpos_d;
      spr_x_q       <= spr_x_d;
      field_q       <= field_d;
      blink_q       <= blink_d;
      sol_q         <= sol_d;
      sof_q         <= sof_d;
      irq_q         <= irq_d;
      match_q       <= match_d;
      x_max_l_q     <= x_max_l_d;
      y_max_l_q     <= y_max_l_d;
    end
  end

  assign raster_x_o        = raster_x_q;
  assign raster_line_o     = raster_line_q;
  assign xpos_o            = xpos_q;
  assign sprite_raster_x_o = spr_x_q;
  assign field_o           = field_q;
  assign blink_ctr_o       = blink_q;
  assign sol_o             = sol_q;
  assign sof_o             = sof_q;
  assign irq_raster_o      = irq_q;

endmodule

// File: tb/tb_raster_timing_gen.sv
// Bench for raster_timing_gen: directed geometry/remap/reset checks plus a randomized run
// compared every clock against an integer reference model.
module tb_raster_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        dot_tick;
  logic [9:0]  x_max;
  logic [8:0]  y_max;
  logic        interlace_en;
  logic [9:0]  xpos_start;
  logic [9:0]  spr_offset;
  logic [3:0]  jump_en;
  logic [39:0] jump_at;
  logic [39:0] jump_to;
  logic [8:0]  raster_cmp;
  logic        cmp_en;
  logic [9:0]  raster_x;
  logic [8:0]  raster_line;
  logic [9:0]  xpos;
  logic [9:0]  sprite_raster_x;
  logic        field;
  logic [5:0]  blink_ctr;
  logic        sol;
  logic        sof;
  logic        irq_raster;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (plain integers)
  int m_rx, m_line, m_xpos, m_spr, m_field, m_blink, m_sol, m_sof, m_irq, m_prev, m_xl, m_yl;

  always #5 clk = ~clk;

  raster_timing_gen dut (
    .clk_dot4x_i       (clk),
    .rst_i             (rst),
    .dot_tick_i        (dot_tick),
    .x_max_i           (x_max),
    .y_max_i           (y_max),
    .interlace_en_i    (interlace_en),
    .xpos_start_i      (xpos_start),
    .spr_offset_i      (spr_offset),
    .jump_en_i         (jump_en),
    .jump_at_i         (jump_at),
    .jump_to_i         (jump_to),
    .raster_cmp_i      (raster_cmp),
    .cmp_en_i          (cmp_en),
    .raster_x_o        (raster_x),
    .raster_line_o     (raster_line),
    .xpos_o            (xpos),
    .sprite_raster_x_o (sprite_raster_x),
    .field_o           (field),
    .blink_ctr_o       (blink_ctr),
    .sol_o             (sol),
    .sof_o             (sof),
    .irq_raster_o      (irq_raster)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Next model state from the current model state and the inputs seen at the coming edge.
  task automatic model_advance();
    int match;
    int hit;
    if (rst) begin
      m_rx = 0; m_line = 0; m_xpos = int'(xpos_start); m_spr = int'(spr_offset);
      m_field = 0; m_blink = 0; m_sol = 0; m_sof = 0; m_irq = 0; m_prev = 0;
      m_xl = int'(x_max); m_yl = int'(y_max);
      return;
    end
    match  = (cmp_en && m_line == int'(raster_cmp)) ? 1 : 0;
    m_irq  = (match == 1 && m_prev == 0) ? 1 : 0;
    m_prev = match;
    m_sol  = 0;
    m_sof  = 0;
    if (!dot_tick) return;
    m_spr = (m_spr < m_xl) ? m_spr + 1 : 0;
    if (m_rx >= m_xl) begin
      m_rx   = 0;
      m_xpos = int'(xpos_start);
      m_sol  = 1;
      if (m_line < (m_yl + ((interlace_en && m_field == 1) ? 1 : 0)) % 512) begin
        m_line++;
      end else begin
        m_line  = 0;
        m_blink = (m_blink + 1) % 64;
        m_field = interlace_en ? 1 - m_field : 0;
        m_xl    = int'(x_max);
        m_yl    = int'(y_max);
        m_sof   = 1;
      end
    end else begin
      hit = -1;
      for (int i = 0; i < 4; i++)
        if (hit < 0 && jump_en[i] && int'(jump_at[i*10 +: 10]) == m_rx) hit = i;
      m_xpos = (hit >= 0) ? int'(jump_to[hit*10 +: 10]) : (m_xpos + 1) % 1024;
      m_rx++;
    end
  endtask

  task automatic compare_model();
    check("raster_x", 32'(raster_x), m_rx);
    check("raster_line", 32'(raster_line), m_line);
    check("xpos", 32'(xpos), m_xpos);
    check("sprite_raster_x", 32'(sprite_raster_x), m_spr);
    check("field", 32'(field), m_field);
    check("blink_ctr", 32'(blink_ctr), m_blink);
    check("sol", 32'(sol), m_sol);
    check("sof", 32'(sof), m_sof);
    check("irq_raster", 32'(irq_raster), m_irq);
  endtask

  task automatic cycle();
    model_advance();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  initial begin
    int sof_at[$];
    rst = 1'b1; dot_tick = 1'b0; interlace_en = 1'b0; cmp_en = 1'b0; raster_cmp = '0;
    x_max = 10'd519; y_max = 9'd261; xpos_start = 10'h19c; spr_offset = 10'd5;
    jump_en = 4'b1111;
    jump_at = {10'd99, 10'd503, 10'd499, 10'd495};
    jump_to = {10'h000, 10'h184, 10'h184, 10'h184};
    #2;
    cycle(); cycle();
    check("rst_raster_x", 32'(raster_x), 0);
    check("rst_xpos", 32'(xpos), 32'h19c);
    check("rst_sprite_x", 32'(sprite_raster_x), 5);
    check("rst_sol_sof_irq", {29'd0, sol, sof, irq_raster}, 0);

    // NTSC-style remap line
    rst = 1'b0; dot_tick = 1'b1;
    for (int n = 1; n <= 520; n++) begin
      cycle();
      if (n == 100) check("remap_jump_to_0", 32'(xpos), 0);
      if (n == 496) check("remap_495", 32'(xpos), 32'h184);
      if (n == 500) check("remap_499", 32'(xpos), 32'h184);
      if (n == 504) check("remap_503", 32'(xpos), 32'h184);
      if (n == 505) check("remap_after", 32'(xpos), 32'h185);
      if (n == 520) begin
        check("wrap_raster_x", 32'(raster_x), 0);
        check("wrap_xpos", 32'(xpos), 32'h19c);
        check("wrap_line", 32'(raster_line), 1);
        check("wrap_sol", 32'(sol), 1);
        check("wrap_sprite_x", 32'(sprite_raster_x), 5);
      end
    end

    // Interlace cadence: 8-pixel lines, 4 lines in field 0, 5 in field 1
    rst = 1'b1; x_max = 10'd7; y_max = 9'd3; interlace_en = 1'b1; jump_en = '0;
    spr_offset = 10'd0;
    cycle();
    rst = 1'b0;
    for (int n = 1; n <= 110; n++) begin
      cycle();
      if (sof) sof_at.push_back(n);
      if (n == 33) check("field_after_sof", 32'(field), 1);
    end
    check("sof_count", sof_at.size(), 3);
    if (sof_at.size() == 3) begin
      check("sof_0", sof_at[0], 32);
      check("sof_1", sof_at[1], 72);
      check("sof_2", sof_at[2], 104);
    end
    check("blink_3", 32'(blink_ctr), 3);

    // Randomized segments against the model
    for (int seg = 0; seg < 8; seg++) begin
      x_max = 10'($urandom_range(3, 40));
      y_max = 9'($urandom_range(2, 12));
      interlace_en = 1'($urandom_range(0, 1));
      xpos_start = 10'($urandom);
      spr_offset = 10'($urandom_range(0, 45));
      jump_en = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        jump_at[i*10 +: 10] = 10'($urandom_range(0, 40));
        jump_to[i*10 +: 10] = 10'($urandom);
      end
      cmp_en = 1'b1;
      raster_cmp = 9'($urandom_range(0, 13));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        dot_tick = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 399) == 0) x_max = 10'($urandom_range(3, 40));
        if ($urandom_range(0, 399) == 0) y_max = 9'($urandom_range(2, 12));
        if ($urandom_range(0, 499) == 0) interlace_en = ~interlace_en;
        if ($urandom_range(0, 199) == 0) jump_en = 4'($urandom);
        if ($urandom_range(0, 49) == 0) raster_cmp = 9'($urandom_range(0, 13));
        if ($urandom_range(0, 79) == 0) raster_cmp = 9'(m_line);
        if ($urandom_range(0, 149) == 0) cmp_en = ~cmp_en;
        rst = ($urandom_range(0, 1499) == 0);
        cycle();
      end
    end

    // Mid-line reset with raster compare on line 0
    rst = 1'b0; dot_tick = 1'b1; x_max = 10'd503; y_max = 9'd311; interlace_en = 1'b0;
    cmp_en = 1'b1; raster_cmp = 9'd0; jump_en = '0; xpos_start = 10'h194; spr_offset = 10'd0;
    for (int c = 0; c < 700; c++) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_raster_x", 32'(raster_x), 0);
    check("midrst_line", 32'(raster_line), 0);
    check("midrst_xpos", 32'(xpos), 32'h194);
    check("midrst_flags", {26'd0, field, sol, sof, irq_raster, blink_ctr != 6'd0, 1'b0}, 0);
    rst = 1'b0;
    cycle();
    check("irq_after_release", 32'(irq_raster), 1);
    cycle();
    check("irq_single_pulse", 32'(irq_raster), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
